// File: rtl/freq_meas_sequencer.sv
// Round-robin sequencer for a shared frequency counter: for each enabled channel it
// switches the mux, settles/clears, gates the counter for a programmable window and publishes the count.
module freq_meas_sequencer #(
  parameter int NCH     = 4,
  parameter int SELW    = $clog2(NCH),
  parameter int CW      = 32,
  parameter int GW      = 32,
  parameter int SETTLE  = 4,
  parameter int CAP_DLY = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            enable,
  input  logic [NCH-1:0]  chan_mask,
  input  logic [GW-1:0]   gate_cycles,
  input  logic [CW-1:0]   cnt_value,
  output logic [SELW-1:0] cnt_sel,
  output logic            cnt_clr,
  output logic            cnt_en,
  output logic            strobe,
  output logic [31:0]     addr,
  output logic [CW-1:0]   value,
  output logic            sweep_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_GATE    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
  localparam logic [GW-1:0]   TMR_SETTLE = GW'(SETTLE - 1);
  localparam logic [GW-1:0]   TMR_CAP    = GW'(CAP_DLY);

  // First set bit of m at or above start, wrapping modulo NCH.
  function automatic logic [SELW-1:0] pick_chan(input logic [NCH-1:0] m,
                                                input logic [SELW-1:0] start);
    logic [SELW-1:0] r;
    logic [SELW-1:0] s;
    logic            found;
    int              idx;
    r     = start;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(start) + i;
      idx = (idx >= NCH) ? idx - NCH : idx;
      s   = idx[SELW-1:0];
      if (!found && m[s]) begin
        r     = s;
        found = 1'b1;
      end else begin
        r     = r;
      end
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [GW-1:0]   tmr_q, tmr_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] pend_chan_q, pend_chan_d;
  logic            pend_go_q, pend_go_d;

  logic [SELW-1:0] cnt_sel_q, cnt_sel_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            cnt_en_q, cnt_en_d;
  logic            strobe_q, strobe_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   value_q, value_d;
  logic            sweep_done_q, sweep_done_d;
  logic            busy_q, busy_d;

  logic            mask_any_s;
  logic [SELW-1:0] chan_next_s;
  logic [SELW-1:0] pick_start_s;
  logic [SELW-1:0] pick_s;

  // Next-channel search: from ptr when idle, from the channel after the current one otherwise.
  always_comb begin
    mask_any_s   = |chan_mask;
    chan_next_s  = (cnt_sel_q == LAST_CH) ? '0 : cnt_sel_q + SELW'(1);
    pick_start_s = (state_q == S_IDLE) ? ptr_q : chan_next_s;
    pick_s       = pick_chan(chan_mask, pick_start_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      ptr_q        <= '0;
      pend_chan_q  <= '0;
      pend_go_q    <= 1'b0;
      cnt_sel_q    <= '0;
      cnt_clr_q    <= 1'b0;
      cnt_en_q     <= 1'b0;
      strobe_q     <= 1'b0;
      addr_q       <= 32'd0;
      value_q      <= '0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      ptr_q        <= ptr_d;
      pend_chan_q  <= pend_chan_d;
      pend_go_q    <= pend_go_d;
      cnt_sel_q    <= cnt_sel_d;
      cnt_clr_q    <= cnt_clr_d;
      cnt_en_q     <= cnt_en_d;
      strobe_q     <= strobe_d;
      addr_q       <= addr_d;
      value_q      <= value_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; the continuation decision is made one cycle before the strobe
  // so that sweep_done can be registered alongside it.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    ptr_d       = ptr_q;
    pend_chan_d = pend_chan_q;
    pend_go_d   = pend_go_q;
    case (state_q)
      S_IDLE: begin
        if (enable && mask_any_s) begin
          state_d = S_SETTLE;
          tmr_d   = TMR_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tmr_q == '0) begin
          state_d = S_GATE;
          tmr_d   = (gate_cycles == '0) ? '0 : gate_cycles - GW'(1);
        end else begin
          tmr_d   = tmr_q - GW'(1);
        end
      end
      S_GATE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tmr_q == '0) begin
          state_d = S_CAPTURE;
          tmr_d   = TMR_CAP;
        end else begin
          tmr_d   = tmr_q - GW'(1);
        end
      end
      S_CAPTURE: begin
        if (tmr_q == '0) begin
          if (pend_go_q && enable) begin
            state_d = S_SETTLE;
            tmr_d   = TMR_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q - GW'(1);
          if (tmr_q == GW'(1)) begin
            ptr_d       = chan_next_s;
            pend_chan_d = pick_s;
            pend_go_d   = enable && mask_any_s;
          end else begin
            pend_go_d   = pend_go_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so every output is a flop.
  always_comb begin
    cnt_sel_d    = cnt_sel_q;
    cnt_clr_d    = (state_d == S_SETTLE);
    cnt_en_d     = (state_d == S_GATE);
    busy_d       = (state_d != S_IDLE);
    strobe_d     = (state_q == S_CAPTURE) && (tmr_q == GW'(1));
    addr_d       = addr_q;
    value_d      = value_q;
    sweep_done_d = 1'b0;
    if (state_q == S_IDLE && state_d == S_SETTLE) begin
      cnt_sel_d = pick_s;
    end else if (state_q == S_CAPTURE && state_d == S_SETTLE) begin
      cnt_sel_d = pend_chan_q;
    end else begin
      cnt_sel_d = cnt_sel_q;
    end
    if (strobe_d) begin
      addr_d       = 32'(cnt_sel_q);
      value_d      = cnt_value;
      sweep_done_d = !(enable && mask_any_s) || (pick_s <= cnt_sel_q);
    end else begin
      sweep_done_d = 1'b0;
    end
  end

  assign cnt_sel    = cnt_sel_q;
  assign cnt_clr    = cnt_clr_q;
  assign cnt_en     = cnt_en_q;
  assign strobe     = strobe_q;
  assign addr       = addr_q;
  assign value      = value_q;
  assign sweep_done = sweep_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Self-checking bench: a behavioural counter drives cnt_value and an event-level
// round-robin model predicts each strobe's cycle, channel, count and sweep flag.
module tb_freq_meas_sequencer;
  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int CW   = 32;
  localparam int GW   = 32;
  localparam int SET  = 4;
  localparam int CD   = 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] value;
    logic        sd;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  mask = '0;
  logic [GW-1:0]   gate = '0;
  logic [CW-1:0]   ctr = '0;
  logic [SELW-1:0] cnt_sel;
  logic            cnt_clr, cnt_en, strobe, sweep_done, busy;
  logic [31:0]     addr;
  logic [CW-1:0]   value;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  rec_t        obs_q[$];
  rec_t        exp_q[$];
  int          obs_en[$];
  int          en_tot = 0, dbl_err = 0, ovl_err = 0, sel_err = 0;
  logic        prev_strobe = 1'b0, prev_clr = 1'b0, rst_prev = 1'b0;
  logic [SELW-1:0] prev_sel = '0;
  int          model_ptr = 0;

  freq_meas_sequencer #(.NCH(NCH), .SELW(SELW), .CW(CW), .GW(GW), .SETTLE(SET), .CAP_DLY(CD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .chan_mask(mask), .gate_cycles(gate),
    .cnt_value(ctr), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .strobe(strobe),
    .addr(addr), .value(value), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle count and the shared edge counter (edges == one per cycle while gated).
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
    if (cnt_clr) ctr <= '0;
    else if (cnt_en) ctr <= ctr + 32'd1;
  end

  // Strobe recorder and sticky protocol-rule counters.
  always @(negedge clk) begin
    if (strobe) begin
      obs_q.push_back(rec_t'{cyc, addr, value, sweep_done});
      obs_en.push_back(en_tot);
    end
    if (cnt_en) en_tot <= en_tot + 1;
    if (strobe && prev_strobe) dbl_err <= dbl_err + 1;
    if (cnt_en && cnt_clr) ovl_err <= ovl_err + 1;
    if (!rst_prev && (cnt_sel !== prev_sel) && !(cnt_clr && !prev_clr)) sel_err <= sel_err + 1;
    prev_strobe <= strobe;
    prev_clr    <= cnt_clr;
    prev_sel    <= cnt_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_set(logic [NCH-1:0] m, int from);
    int idx;
    for (int i = 0; i < NCH; i++) begin
      idx = (from + i) % NCH;
      if (m[idx[SELW-1:0]]) return idx;
    end
    return -1;
  endfunction

  // Expected strobes for n back-to-back measurements picked starting at cycle t0.
  task automatic build_exp(int unsigned t0, int p, logic [NCH-1:0] m, int g, int n);
    int geff, c, nx;
    int unsigned t;
    geff = (g == 0) ? 1 : g;
    t = t0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      c  = first_set(m, p);
      nx = first_set(m, (c + 1) % NCH);
      t  = t + SET + geff + CD + 1;
      exp_q.push_back(rec_t'{t, c, geff, nx <= c});
      p  = (c + 1) % NCH;
    end
    model_ptr = p;
  endtask

  task automatic wait_strobes(int n, int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
  endtask

  task automatic apply_reset();
    enable = 1'b0; mask = '0; gate = '0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    obs_q.delete(); obs_en.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mask = 4'b1111; gate = 32'd5;
    tick(); tick();
    n_cmp++; if (cnt_sel !== 2'd0) begin n_err++; $display("FAIL reset_cnt_sel: got %0d want 0", cnt_sel); end
    n_cmp++; if (cnt_clr !== 1'b0) begin n_err++; $display("FAIL reset_cnt_clr: got %0b want 0", cnt_clr); end
    n_cmp++; if (cnt_en !== 1'b0) begin n_err++; $display("FAIL reset_cnt_en: got %0b want 0", cnt_en); end
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %0b want 0", strobe); end
    n_cmp++; if (addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", addr); end
    n_cmp++; if (value !== 32'd0) begin n_err++; $display("FAIL reset_value: got %0d want 0", value); end
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL reset_sweep_done: got %0b want 0", sweep_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    enable = 1'b0; rst = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if ({busy, cnt_clr} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset: got busy/clr=%b want 00", {busy, cnt_clr}); end
  endtask

  task automatic test_single();
    int unsigned t0;
    apply_reset();
    mask = 4'b0001; gate = 32'd100; enable = 1'b1; t0 = cyc;
    build_exp(t0, 0, mask, 100, 3);
    wait_strobes(3, 3 * 107 + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 3) begin n_err++; $display("FAIL single_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single[%0d]: got cyc=%0d addr=%0d val=%0d sd=%0b want cyc=%0d addr=%0d val=%0d sd=%0b",
                 i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].value, obs_q[i].sd, exp_q[i].cyc, exp_q[i].addr, exp_q[i].value, exp_q[i].sd);
      end
    end
  endtask

  task automatic test_alternate();
    int unsigned t0;
    apply_reset();
    mask = 4'b1010; gate = 32'd10; enable = 1'b1; t0 = cyc;
    build_exp(t0, 0, mask, 10, 4);
    wait_strobes(4, 4 * 17 + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL alt_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL alt[%0d]: got cyc=%0d addr=%0d val=%0d sd=%0b want cyc=%0d addr=%0d val=%0d sd=%0b",
                 i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].value, obs_q[i].sd, exp_q[i].cyc, exp_q[i].addr, exp_q[i].value, exp_q[i].sd);
      end
    end
  endtask

  task automatic test_gate_zero();
    int unsigned t0;
    int en0;
    apply_reset();
    mask = 4'($urandom_range(1, 15)); gate = '0; en0 = en_tot; enable = 1'b1; t0 = cyc;
    build_exp(t0, 0, mask, 0, 4);
    wait_strobes(4, 4 * 8 + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL g0_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL g0[%0d] mask=%b: got cyc=%0d addr=%0d val=%0d sd=%0b want cyc=%0d addr=%0d val=%0d sd=%0b",
                 i, mask, obs_q[i].cyc, obs_q[i].addr, obs_q[i].value, obs_q[i].sd, exp_q[i].cyc, exp_q[i].addr, exp_q[i].value, exp_q[i].sd);
      end
    end
    if (obs_en.size() >= 4) begin
      n_cmp++;
      if (obs_en[3] - en0 != 4) begin n_err++; $display("FAIL g0_en_cycles: got %0d want 4", obs_en[3] - en0); end
    end
  endtask

  task automatic test_abort();
    int unsigned t0;
    int g;
    apply_reset();
    g = int'($urandom_range(8, 40));
    mask = 4'b0100 | (4'($urandom_range(0, 1)) << 3); gate = 32'(g); enable = 1'b1; t0 = cyc;
    while (cyc < t0 + SET + 5) tick();
    n_cmp++; if (cnt_en !== 1'b1) begin n_err++; $display("FAIL abort_in_gate: got cnt_en=%0b want 1", cnt_en); end
    enable = 1'b0;
    tick();
    n_cmp++; if ({cnt_en, cnt_clr, busy} !== 3'b000) begin n_err++; $display("FAIL abort_outputs: got en/clr/busy=%b want 000", {cnt_en, cnt_clr, busy}); end
    repeat (g + 10) tick();
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_nostrobe: got %0d strobes want 0", obs_q.size()); end
    enable = 1'b1; t0 = cyc;
    build_exp(t0, 0, mask, g, 1);
    wait_strobes(1, g + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL abort_resume_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL abort_resume: got cyc=%0d addr=%0d val=%0d want cyc=%0d addr=%0d val=%0d",
                 obs_q[0].cyc, obs_q[0].addr, obs_q[0].value, exp_q[0].cyc, exp_q[0].addr, exp_q[0].value);
      end
    end
  endtask

  task automatic test_reset_mid_gate();
    int unsigned t0;
    int g;
    apply_reset();
    g = int'($urandom_range(10, 30));
    mask = 4'b1000; gate = 32'(g); enable = 1'b1; t0 = cyc;
    while (cyc < t0 + SET + 3) tick();
    n_cmp++; if ({cnt_sel, cnt_en} !== 3'b111) begin n_err++; $display("FAIL rmg_pre: got sel=%0d en=%0b want sel=3 en=1", cnt_sel, cnt_en); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({cnt_sel, cnt_clr, cnt_en, strobe, addr, value, sweep_done, busy} !== '0) begin
      n_err++;
      $display("FAIL rmg_zero: got sel=%0d clr=%0b en=%0b stb=%0b addr=%0d val=%0d sd=%0b busy=%0b want all 0",
               cnt_sel, cnt_clr, cnt_en, strobe, addr, value, sweep_done, busy);
    end
    rst = 1'b0; mask = 4'($urandom_range(1, 15)); obs_q.delete(); t0 = cyc;
    build_exp(t0, 0, mask, g, 1);
    wait_strobes(1, g + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL rmg_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL rmg_first mask=%b: got cyc=%0d addr=%0d val=%0d want cyc=%0d addr=%0d val=%0d",
                 mask, obs_q[0].cyc, obs_q[0].addr, obs_q[0].value, exp_q[0].cyc, exp_q[0].addr, exp_q[0].value);
      end
    end
  endtask

  task automatic test_empty_mask();
    int unsigned t0;
    int g, act;
    apply_reset();
    g = int'($urandom_range(5, 30));
    mask = '0; gate = 32'(g); enable = 1'b1; act = 0;
    repeat (200) begin
      tick();
      if (busy || cnt_en || cnt_clr || strobe) act++;
    end
    n_cmp++; if (act != 0) begin n_err++; $display("FAIL empty_active: got %0d active cycles want 0", act); end
    mask = 4'b0100; t0 = cyc;
    build_exp(t0, 0, mask, g, 1);
    wait_strobes(1, g + 20);
    enable = 1'b0; tick(); tick(); tick();
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL empty_then_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL empty_then_first: got cyc=%0d addr=%0d val=%0d want cyc=%0d addr=%0d val=%0d",
                 obs_q[0].cyc, obs_q[0].addr, obs_q[0].value, exp_q[0].cyc, exp_q[0].addr, exp_q[0].value);
      end
    end
  endtask

  task automatic test_random_sweeps();
    int unsigned t0;
    int p, g, n;
    apply_reset();
    p = 0;
    for (int it = 0; it < 4; it++) begin
      g = int'($urandom_range(0, 20));
      n = int'($urandom_range(3, 6));
      mask = 4'($urandom_range(1, 15)); gate = 32'(g);
      obs_q.delete();
      enable = 1'b1; t0 = cyc;
      build_exp(t0, p, mask, g, n);
      wait_strobes(n, n * (SET + 21 + CD + 1) + 20);
      enable = 1'b0; tick(); tick(); tick();
      n_cmp++; if (obs_q.size() != n) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_q.size(), n); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rnd%0d[%0d] mask=%b gate=%0d: got cyc=%0d addr=%0d val=%0d sd=%0b want cyc=%0d addr=%0d val=%0d sd=%0b",
                   it, i, mask, g, obs_q[i].cyc, obs_q[i].addr, obs_q[i].value, obs_q[i].sd, exp_q[i].cyc, exp_q[i].addr, exp_q[i].value, exp_q[i].sd);
        end
      end
      p = model_ptr;
    end
  endtask

  task automatic test_invariants();
    n_cmp++; if (dbl_err != 0) begin n_err++; $display("FAIL strobe_twice: got %0d occurrences want 0", dbl_err); end
    n_cmp++; if (ovl_err != 0) begin n_err++; $display("FAIL en_clr_overlap: got %0d cycles want 0", ovl_err); end
    n_cmp++; if (sel_err != 0) begin n_err++; $display("FAIL sel_outside_settle_entry: got %0d changes want 0", sel_err); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_gate_zero();
    test_abort();
    test_reset_mid_gate();
    test_empty_mask();
    test_random_sweeps();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
